// File: rtl/truth_table_sweeper_if.sv
// Bundle of the sweeper's control, DUT-facing and log signals.
// master: the side that drives start/abort/exp_table and returns the DUT response.
// slave : the sweeper itself.
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
) ();
  logic                   start;
  logic                   abort;
  logic [(2**N_IN)-1:0]   exp_table;
  logic [N_IN-1:0]        dut_in;
  logic                   dut_out;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          err_count;
  logic                   fail_valid;
  logic [N_IN-1:0]        fail_vec;
  logic                   log_valid;
  logic [N_IN-1:0]        log_vec;
  logic                   log_z;

  modport master (
    output start, abort, exp_table, dut_out,
    input  dut_in, busy, done, pass, err_count, fail_valid, fail_vec,
           log_valid, log_vec, log_z
  );

  modport slave (
    input  start, abort, exp_table, dut_out,
    output dut_in, busy, done, pass, err_count, fail_valid, fail_vec,
           log_valid, log_vec, log_z
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector of a small
// combinational DUT in ascending order, holds it SETTLE+1 cycles, samples the
// response on the last cycle, compares against a latched expected table and
// emits one log record per row plus a pass/fail summary.
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input logic                 clk,
  input logic                 reset,
  truth_table_sweeper_if.slave bus
);

  localparam int              ROWS       = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_VEC   = N_IN'(ROWS - 1);
  localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [N_IN-1:0]    vec, vec_nx;
  logic [3:0]         cnt, cnt_nx;
  logic [ROWS-1:0]    tbl_q, tbl_nx;
  logic [N_IN-1:0]    dut_in_q, dut_in_nx;
  logic               busy_q, busy_nx;
  logic               done_q, done_nx;
  logic               pass_q, pass_nx;
  logic [N_IN:0]      err_q, err_nx;
  logic               fv_q, fv_nx;
  logic [N_IN-1:0]    fvec_q, fvec_nx;
  logic               lv_q, lv_nx;
  logic [N_IN-1:0]    lvec_q, lvec_nx;
  logic               lz_q, lz_nx;
  logic               mismatch;

  // Next-state and next-output computation; every register holds by default,
  // the two pulse outputs (done, log_valid) drop by default.
  always_comb begin
    state_nx  = state;
    vec_nx    = vec;
    cnt_nx    = cnt;
    tbl_nx    = tbl_q;
    dut_in_nx = dut_in_q;
    busy_nx   = busy_q;
    done_nx   = 1'b0;
    pass_nx   = pass_q;
    err_nx    = err_q;
    fv_nx     = fv_q;
    fvec_nx   = fvec_q;
    lv_nx     = 1'b0;
    lvec_nx   = lvec_q;
    lz_nx     = lz_q;
    mismatch  = (bus.dut_out != tbl_q[vec]);

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          // Start beats a simultaneous abort: abort is not looked at here.
          tbl_nx    = bus.exp_table;
          err_nx    = {(N_IN+1){1'b0}};
          fv_nx     = 1'b0;
          fvec_nx   = {N_IN{1'b0}};
          pass_nx   = 1'b0;
          vec_nx    = {N_IN{1'b0}};
          cnt_nx    = SETTLE_CNT;
          dut_in_nx = {N_IN{1'b0}};
          busy_nx   = 1'b1;
          state_nx  = ST_SWEEP;
        end else begin
          dut_in_nx = {N_IN{1'b0}};
          busy_nx   = 1'b0;
        end
      end

      ST_SWEEP: begin
        if (bus.abort) begin
          // Abort wins even on the final sample edge: no log, no done.
          state_nx  = ST_IDLE;
          dut_in_nx = {N_IN{1'b0}};
          busy_nx   = 1'b0;
          pass_nx   = 1'b0;
        end else if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          lv_nx   = 1'b1;
          lvec_nx = vec;
          lz_nx   = bus.dut_out;
          if (mismatch) begin
            err_nx = err_q + {{N_IN{1'b0}}, 1'b1};
            if (!fv_q) begin
              fvec_nx = vec;
              fv_nx   = 1'b1;
            end else begin
              fvec_nx = fvec_q;
            end
          end else begin
            err_nx = err_q;
          end
          if (vec == LAST_VEC) begin
            // Final vector is terminal; the counter never wraps.
            state_nx  = ST_DONE;
            dut_in_nx = {N_IN{1'b0}};
            busy_nx   = 1'b0;
            done_nx   = 1'b1;
            pass_nx   = (err_nx == {(N_IN+1){1'b0}});
          end else begin
            vec_nx    = vec + {{(N_IN-1){1'b0}}, 1'b1};
            dut_in_nx = vec + {{(N_IN-1){1'b0}}, 1'b1};
            cnt_nx    = SETTLE_CNT;
          end
        end
      end

      ST_DONE: begin
        // Single completion cycle; start is deliberately not sampled here.
        state_nx  = ST_IDLE;
        dut_in_nx = {N_IN{1'b0}};
        busy_nx   = 1'b0;
      end

      default: begin
        state_nx  = ST_IDLE;
        dut_in_nx = {N_IN{1'b0}};
        busy_nx   = 1'b0;
      end
    endcase
  end

  // State and output registers; asynchronous reset abandons any sweep silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      vec      <= {N_IN{1'b0}};
      cnt      <= 4'd0;
      tbl_q    <= {ROWS{1'b0}};
      dut_in_q <= {N_IN{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= {(N_IN+1){1'b0}};
      fv_q     <= 1'b0;
      fvec_q   <= {N_IN{1'b0}};
      lv_q     <= 1'b0;
      lvec_q   <= {N_IN{1'b0}};
      lz_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      vec      <= vec_nx;
      cnt      <= cnt_nx;
      tbl_q    <= tbl_nx;
      dut_in_q <= dut_in_nx;
      busy_q   <= busy_nx;
      done_q   <= done_nx;
      pass_q   <= pass_nx;
      err_q    <= err_nx;
      fv_q     <= fv_nx;
      fvec_q   <= fvec_nx;
      lv_q     <= lv_nx;
      lvec_q   <= lvec_nx;
      lz_q     <= lz_nx;
    end
  end

  assign bus.dut_in     = dut_in_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.fail_vec   = fvec_q;
  assign bus.log_valid  = lv_q;
  assign bus.log_vec    = lvec_q;
  assign bus.log_z      = lz_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance at N_IN=3/SETTLE=1, one at
// N_IN=4/SETTLE=0, each driving a table-defined combinational DUT. Results
// are checked against a row-by-row model of what an exhaustive sweep yields.
module tb_truth_table_sweeper;
  localparam int NA = 3, SA = 1, RA = 8;
  localparam int NB = 4, SB = 0, RB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0]  tt_a = 8'h96;
  logic [15:0] tt_b = 16'h6996;

  truth_table_sweeper_if #(.N_IN(NA)) bus_a ();
  truth_table_sweeper_if #(.N_IN(NB)) bus_b ();

  truth_table_sweeper #(.N_IN(NA), .SETTLE(SA)) u_a (.clk(clk), .reset(rst), .bus(bus_a));
  truth_table_sweeper #(.N_IN(NB), .SETTLE(SB)) u_b (.clk(clk), .reset(rst), .bus(bus_b));

  assign bus_a.dut_out = tt_a[bus_a.dut_in];
  assign bus_b.dut_out = tt_b[bus_b.dut_in];

  always #5 clk = ~clk;

  // Edge counter used as the time base for the expected schedule.
  always @(posedge clk) cyc <= cyc + 1;

  int log_a[$];
  int log_b[$];
  int done_cnt_a = 0, done_cyc_a = 0;
  int done_cnt_b = 0, done_cyc_b = 0;

  // Capture log records and done pulses of both instances.
  always @(negedge clk) begin
    if (bus_a.log_valid) log_a.push_back(int'(bus_a.log_vec) * 2 + int'(bus_a.log_z));
    if (bus_a.done) begin done_cnt_a++; done_cyc_a = cyc; end
    if (bus_b.log_valid) log_b.push_back(int'(bus_b.log_vec) * 2 + int'(bus_b.log_z));
    if (bus_b.done) begin done_cnt_b++; done_cyc_b = cyc; end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observations gathered by a run, handed to the model check.
  int obs_log[$];
  int obs_dt, obs_pass, obs_err, obs_fv, obs_fvec;
  int t0, base_log, base_done;

  task automatic check_result(input string tag, input int rows, input int settle,
                              input logic [15:0] tbl, input logic [15:0] tt);
    int errs = 0;
    int first = -1;
    for (int k = 0; k < rows; k++) begin
      if (tt[k] != tbl[k]) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    check_eq({tag, ".nlog"}, obs_log.size(), rows);
    for (int k = 0; k < rows && k < obs_log.size(); k++)
      check_eq({tag, ".logrow"}, obs_log[k], k * 2 + int'(tt[k]));
    check_eq({tag, ".done_t"}, obs_dt, rows * (settle + 1));
    check_eq({tag, ".err"}, obs_err, errs);
    check_eq({tag, ".fail_valid"}, obs_fv, (errs != 0) ? 1 : 0);
    check_eq({tag, ".fail_vec"}, obs_fvec, (first < 0) ? 0 : first);
    check_eq({tag, ".pass"}, obs_pass, (errs == 0) ? 1 : 0);
  endtask

  task automatic start_a(input logic [7:0] tbl, input logic [7:0] tt);
    tt_a = tt;
    bus_a.exp_table = tbl;
    @(negedge clk); #1;
    base_log = log_a.size();
    base_done = done_cnt_a;
    bus_a.start = 1'b1;
    @(negedge clk); #1;
    bus_a.start = 1'b0;
    t0 = cyc;
  endtask

  task automatic run_a(input string tag, input logic [7:0] tbl, input logic [7:0] tt);
    int bound = 0;
    int el;
    start_a(tbl, tt);
    while (done_cnt_a == base_done && bound < 400) begin
      el = cyc - t0;
      if (el < RA * (SA + 1)) begin
        check_eq({tag, ".busy"}, int'(bus_a.busy), 1);
        check_eq({tag, ".dut_in"}, int'(bus_a.dut_in), el / (SA + 1));
      end
      @(negedge clk); #1;
      bound++;
    end
    check_eq({tag, ".done_seen"}, done_cnt_a - base_done, 1);
    check_eq({tag, ".busy_in_done"}, int'(bus_a.busy), 0);
    check_eq({tag, ".dut_in_in_done"}, int'(bus_a.dut_in), 0);
    obs_log.delete();
    for (int i = base_log; i < log_a.size(); i++) obs_log.push_back(log_a[i]);
    obs_dt = done_cyc_a - t0;
    obs_pass = int'(bus_a.pass);
    obs_err = int'(bus_a.err_count);
    obs_fv = int'(bus_a.fail_valid);
    obs_fvec = int'(bus_a.fail_vec);
    check_result(tag, RA, SA, {8'h00, tbl}, {8'h00, tt});
  endtask

  task automatic run_b(input string tag, input logic [15:0] tbl, input logic [15:0] tt);
    int bound = 0;
    int el;
    tt_b = tt;
    bus_b.exp_table = tbl;
    @(negedge clk); #1;
    base_log = log_b.size();
    base_done = done_cnt_b;
    bus_b.start = 1'b1;
    @(negedge clk); #1;
    bus_b.start = 1'b0;
    t0 = cyc;
    while (done_cnt_b == base_done && bound < 400) begin
      el = cyc - t0;
      if (el < RB * (SB + 1))
        check_eq({tag, ".dut_in"}, int'(bus_b.dut_in), el / (SB + 1));
      @(negedge clk); #1;
      bound++;
    end
    check_eq({tag, ".done_seen"}, done_cnt_b - base_done, 1);
    obs_log.delete();
    for (int i = base_log; i < log_b.size(); i++) obs_log.push_back(log_b[i]);
    obs_dt = done_cyc_b - t0;
    obs_pass = int'(bus_b.pass);
    obs_err = int'(bus_b.err_count);
    obs_fv = int'(bus_b.fail_valid);
    obs_fvec = int'(bus_b.fail_vec);
    check_result(tag, RB, SB, tbl, tt);
  endtask

  task automatic wait_vec_a(input int v);
    int n = 0;
    while (int'(bus_a.dut_in) != v && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("wait_vec", int'(bus_a.dut_in), v);
  endtask

  task automatic check_idle_a(input string tag);
    check_eq({tag, ".busy"}, int'(bus_a.busy), 0);
    check_eq({tag, ".dut_in"}, int'(bus_a.dut_in), 0);
    check_eq({tag, ".done"}, int'(bus_a.done), 0);
  endtask

  initial begin
    logic [7:0]  ra_tbl, ra_tt;
    logic [15:0] rb_tbl, rb_tt;
    int snap;

    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.exp_table = 8'h00;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.exp_table = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check_idle_a("rst");
    check_eq("rst.pass", int'(bus_a.pass), 0);
    check_eq("rst.err", int'(bus_a.err_count), 0);
    check_eq("rst.log_valid", int'(bus_a.log_valid), 0);
    check_eq("rst.b_busy", int'(bus_b.busy), 0);

    // Directed parity sweeps: correct table, one wrong row, all rows wrong.
    run_a("par96", 8'h96, 8'h96);
    // start during the DONE cycle must be ignored.
    bus_a.start = 1'b1;
    @(negedge clk); #1;
    bus_a.start = 1'b0;
    @(negedge clk); #1;
    check_idle_a("start_in_done");
    run_a("par97", 8'h97, 8'h96);
    run_a("par69", 8'h69, 8'h96);

    // Table change and re-start mid-sweep are ignored; abort in vector 3.
    start_a(8'h96, 8'h96);
    wait_vec_a(2);
    bus_a.exp_table = 8'h00;
    bus_a.start = 1'b1;
    @(negedge clk); #1;
    bus_a.start = 1'b0;
    wait_vec_a(3);
    bus_a.abort = 1'b1;
    @(negedge clk); #1;
    bus_a.abort = 1'b0;
    check_idle_a("abort3");
    check_eq("abort3.pass", int'(bus_a.pass), 0);
    check_eq("abort3.err", int'(bus_a.err_count), 0);
    check_eq("abort3.fail_valid", int'(bus_a.fail_valid), 0);
    repeat (20) @(negedge clk);
    #1;
    check_eq("abort3.nlog", log_a.size() - base_log, 3);
    check_eq("abort3.no_done", done_cnt_a - base_done, 0);
    check_eq("abort3.still_idle", int'(bus_a.busy), 0);

    // Abort arriving with the final sample edge wins over log and done.
    start_a(8'h96, 8'h96);
    wait_vec_a(7);
    @(negedge clk); #1;
    bus_a.abort = 1'b1;
    @(negedge clk); #1;
    bus_a.abort = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check_eq("abort_last.nlog", log_a.size() - base_log, 7);
    check_eq("abort_last.no_done", done_cnt_a - base_done, 0);
    check_eq("abort_last.pass", int'(bus_a.pass), 0);
    check_idle_a("abort_last");

    // Four-input XOR with back-to-back samples.
    run_b("xor4", 16'h6996, 16'h6996);

    // Asynchronous reset between edges mid-sweep with non-zero state.
    start_a(8'h97, 8'h96);
    wait_vec_a(4);
    snap = done_cnt_a;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle_a("async_rst");
    check_eq("async_rst.pass", int'(bus_a.pass), 0);
    check_eq("async_rst.err", int'(bus_a.err_count), 0);
    check_eq("async_rst.fail_valid", int'(bus_a.fail_valid), 0);
    check_eq("async_rst.fail_vec", int'(bus_a.fail_vec), 0);
    check_eq("async_rst.log_valid", int'(bus_a.log_valid), 0);
    check_eq("async_rst.log_vec", int'(bus_a.log_vec), 0);
    check_eq("async_rst.log_z", int'(bus_a.log_z), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("async_rst.no_done", done_cnt_a - snap, 0);
    check_idle_a("async_rst.after");
    run_a("post_rst", 8'h96, 8'h96);

    // Randomized DUT functions and expected tables.
    for (int i = 0; i < 6; i++) begin
      ra_tt = 8'($urandom);
      ra_tbl = ($urandom_range(0, 2) == 0) ? ra_tt : 8'($urandom);
      run_a("rand_a", ra_tbl, ra_tt);
    end
    for (int i = 0; i < 4; i++) begin
      rb_tt = 16'($urandom);
      rb_tbl = ($urandom_range(0, 2) == 0) ? rb_tt : (rb_tt ^ 16'($urandom_range(0, 65535)));
      run_b("rand_b", rb_tbl, rb_tt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Synthesizable, self-running exhaustive stimulus/checker for an N_IN-input, 1-output combinational DUT.
- Steps through all 2^N_IN input vectors in ascending order and holds each for a programmable settle time.
- Samples the DUT output, compares it against a caller-supplied expected truth table, and streams one log record per row.
- Reports mismatch count, first failing vector and pass/fail. It is the on-chip replacement for hand-written stimulus blocks that step a, b, c every 10 time units and print Z.

Parameters:
- N_IN, 3, number of DUT inputs (1..8).
- SETTLE, 1, extra hold cycles per vector before sampling (0..15). Each vector is held for SETTLE+1 cycles.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin sweep. Sampled only in IDLE.
- abort  input  1  synchronous abandon of an active sweep.
- exp_table  input  2**N_IN  expected output. Bit k = expected z for input vector k. Latched at start.
- dut_in  output  N_IN  vector driven to DUT. Bit N_IN-1 is the leftmost input (a).
- dut_out  input  1  DUT response z.
- busy  output  1  high in SWEEP states.
- done  output  1  one-cycle pulse at sweep completion.
- pass  output  1  err_count==0 for the last completed sweep. Held until next start.
- err_count  output  N_IN+1  mismatches in the current or last sweep. Saturation is never needed (max 2^N_IN).
- fail_valid  output  1  at least one mismatch this sweep (sticky).
- fail_vec  output  N_IN  first mismatching vector. Valid when fail_valid=1.
- log_valid  output  1  one-cycle pulse per sampled row.
- log_vec  output  N_IN  row vector for the log record.
- log_z  output  1  sampled dut_out for the log record.

Behaviour:
Reset:
- Asynchronous reset forces state IDLE.
- dut_in, busy, done, pass, err_count, fail_valid, fail_vec, log_valid, log_vec, log_z all become 0.
- The latched table and settle counter are cleared.
- Reset mid-sweep abandons the sweep; there is no done pulse.

States:
- IDLE: busy=0, dut_in=0.
  - start=1 at an edge latches exp_table.
  - Clears err_count, fail_valid, fail_vec and pass.
  - Sets vec=0 and cnt=SETTLE, then moves to SWEEP.
- SWEEP: busy=1, dut_in=vec.
  - If cnt!=0: cnt decrements at each edge.
  - If cnt==0, this edge is the sample edge:
    - log_valid<=1, log_vec<=vec, log_z<=dut_out.
    - If dut_out != table[vec]: err_count+1. If fail_valid==0, also fail_vec<=vec and fail_valid<=1.
    - If vec==2^N_IN-1: go to DONE and set pass<=(final err_count==0).
    - Otherwise: vec+1, cnt=SETTLE.
- DONE: done=1 for exactly one cycle, busy=0, dut_in=0. Next edge goes to IDLE. start is ignored in DONE.

Timing:
- With the start edge at T0, vector k is driven from edge T0+k*(SETTLE+1) to edge T0+(k+1)*(SETTLE+1). The latter is its sample edge.
- done is high in the cycle after edge T0+2^N_IN*(SETTLE+1).
- log_valid is high in the cycle after each sample edge. Pulses are back-to-back when SETTLE=0.

Boundary rules:
- start while busy or in DONE: ignored.
- exp_table changes mid-sweep: ignored, because the table is latched.
- abort=1 in SWEEP:
  - Next edge goes to IDLE with dut_in=0 and pass=0, and no done pulse.
  - err_count and fail_* keep their partial values.
  - If abort coincides with the final sample edge, abort wins: no log pulse and no done.
  - abort in IDLE or DONE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- The vec counter never wraps. The final vector is terminal.
- err_count maximum is 2^N_IN, which fits in N_IN+1 bits.

Test Plan:
1. Parity DUT (z=a^b^c), N_IN=3, SETTLE=1, exp_table=8'h96, start pulse at T0.
   - dut_in steps 0..7, each held 2 cycles.
   - Log pairs are (0,0)(1,1)(2,1)(3,0)(4,1)(5,0)(6,0)(7,1).
   - done is high in the cycle after edge T0+16.
   - pass=1, err_count=0, fail_valid=0.
2. Same DUT, exp_table=8'h97.
   - err_count=1, fail_vec=0, fail_valid=1, pass=0.
3. Same DUT, exp_table=8'h69 (all rows wrong).
   - err_count=4'b1000, fail_vec=0, pass=0, with no overflow.
4. Start sweep with exp_table=8'h96, then during vector 2:
   - Change exp_table to 8'h00 and pulse start: both ignored, result pass=1.
   - Then assert abort during vector 3: returns to IDLE with dut_in=0, no done, pass=0, and exactly 3 log pulses.
5. SETTLE=0, N_IN=4, 4-input XOR DUT, exp_table=16'h6996.
   - 16 consecutive log pulses, done in the cycle after edge T0+16, pass=1.
6. Assert reset asynchronously between clock edges mid-sweep.
   - All outputs are 0 immediately and the state is IDLE.
   - A fresh start afterwards completes normally with pass=1.
